// File: rtl/issue_ctrl.sv
// In-order issue control for the ID->EX boundary: register scoreboard, multiplier and
// memory occupancy tracking, hazard detection and a saturating stall counter.
module issue_ctrl #(
  parameter int unsigned MUL_LAT = 3
) (
  input  logic        clk,
  input  logic        rstn,
  // Decoded instruction in ID
  input  logic        id_valid,
  input  logic [14:0] id_rs,
  input  logic [1:0]  id_reg_wb,
  input  logic [1:0]  id_mem,
  input  logic [3:0]  id_ex,
  input  logic        flush,
  // Completion events
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic        mem_done,
  // Issue handshake and EX stage registers
  output logic        id_ready,
  output logic        ex_valid,
  output logic [14:0] ex_rs,
  output logic [1:0]  ex_reg_wb,
  output logic [1:0]  ex_mem,
  output logic [3:0]  ex_ex,
  // Status
  output logic [31:0] pending,
  output logic        mul_busy,
  output logic        mem_busy,
  output logic [15:0] stall_cnt
);

  localparam logic [3:0]  MulLoad = 4'(MUL_LAT);
  localparam logic [15:0] CntMax  = 16'hFFFF;

  // Decoded fields
  logic [4:0] rs0, rs1, rs2;
  logic       reg_write;
  logic       is_mul;
  logic       is_mem;
  logic       rs0_is_src;
  logic       has_dst;

  // Hazards and issue decision
  logic       raw_hazard;
  logic       waw_hazard;
  logic       struct_hazard;
  logic       stall;
  logic       issue;
  logic       count_stall;

  // State
  logic [31:0] pending_q, pending_d;
  logic [3:0]  mul_cnt_q, mul_cnt_d;
  logic        mem_busy_q, mem_busy_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        ex_valid_q;
  logic [14:0] ex_rs_q;
  logic [1:0]  ex_reg_wb_q;
  logic [1:0]  ex_mem_q;
  logic [3:0]  ex_ex_q;

  assign rs0       = id_rs[4:0];
  assign rs1       = id_rs[9:5];
  assign rs2       = id_rs[14:10];
  assign reg_write = id_reg_wb[1];
  assign is_mul    = id_ex[2];
  assign is_mem    = id_mem != 2'b00;

  // Stores and non-writing branches read rs0 as a third operand.
  assign rs0_is_src = id_mem[0] | (id_ex[3] & ~reg_write);
  assign has_dst    = reg_write & (rs0 != 5'd0);

  // Hazards look only at registered state; pending_q[0] is held at zero.
  assign raw_hazard    = pending_q[rs1] | pending_q[rs2] | (rs0_is_src & pending_q[rs0]);
  assign waw_hazard    = has_dst & pending_q[rs0];
  assign struct_hazard = (is_mul & mul_busy) | (is_mem & mem_busy_q);
  assign stall         = raw_hazard | waw_hazard | struct_hazard;

  assign issue       = id_valid & ~flush & ~stall;
  assign id_ready    = issue | (id_valid & flush);
  assign count_stall = id_valid & ~flush & ~issue;

  // Scoreboard: a same-cycle clear and set of one register leaves it set.
  always_comb begin
    pending_d = pending_q;
    if (wb_valid) begin
      pending_d[wb_rd] = 1'b0;
    end
    if (issue && has_dst) begin
      pending_d[rs0] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_comb begin
    mul_cnt_d = mul_cnt_q;
    if (issue && is_mul) begin
      mul_cnt_d = MulLoad;
    end else if (mul_cnt_q != 4'd0) begin
      mul_cnt_d = mul_cnt_q - 4'd1;
    end
  end

  always_comb begin
    mem_busy_d = mem_busy_q;
    if (issue && is_mem) begin
      mem_busy_d = 1'b1;
    end else if (mem_done) begin
      mem_busy_d = 1'b0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (count_stall && (stall_cnt_q != CntMax)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pending_q   <= '0;
      mul_cnt_q   <= '0;
      mem_busy_q  <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      pending_q   <= pending_d;
      mul_cnt_q   <= mul_cnt_d;
      mem_busy_q  <= mem_busy_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // EX payload only moves on issue, so a flushed or stalled slot leaves it untouched.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ex_valid_q  <= 1'b0;
      ex_rs_q     <= '0;
      ex_reg_wb_q <= '0;
      ex_mem_q    <= '0;
      ex_ex_q     <= '0;
    end else begin
      ex_valid_q <= issue;
      if (issue) begin
        ex_rs_q     <= id_rs;
        ex_reg_wb_q <= id_reg_wb;
        ex_mem_q    <= id_mem;
        ex_ex_q     <= id_ex;
      end
    end
  end

  assign ex_valid  = ex_valid_q;
  assign ex_rs     = ex_rs_q;
  assign ex_reg_wb = ex_reg_wb_q;
  assign ex_mem    = ex_mem_q;
  assign ex_ex     = ex_ex_q;
  assign pending   = pending_q;
  assign mul_busy  = mul_cnt_q != 4'd0;
  assign mem_busy  = mem_busy_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_issue_ctrl.sv
// Bench for issue_ctrl: directed hazard scenarios plus a randomized run, all checked
// against a cycle-level behavioural model of the issue rules.
module tb_issue_ctrl;

  localparam int unsigned MulLat = 3;

  logic        clk = 1'b0;
  logic        rstn;
  logic        id_valid;
  logic [14:0] id_rs;
  logic [1:0]  id_reg_wb;
  logic [1:0]  id_mem;
  logic [3:0]  id_ex;
  logic        flush;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        mem_done;
  logic        id_ready;
  logic        ex_valid;
  logic [14:0] ex_rs;
  logic [1:0]  ex_reg_wb;
  logic [1:0]  ex_mem;
  logic [3:0]  ex_ex;
  logic [31:0] pending;
  logic        mul_busy;
  logic        mem_busy;
  logic [15:0] stall_cnt;

  issue_ctrl #(.MUL_LAT(MulLat)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .id_valid  (id_valid),
    .id_rs     (id_rs),
    .id_reg_wb (id_reg_wb),
    .id_mem    (id_mem),
    .id_ex     (id_ex),
    .flush     (flush),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .mem_done  (mem_done),
    .id_ready  (id_ready),
    .ex_valid  (ex_valid),
    .ex_rs     (ex_rs),
    .ex_reg_wb (ex_reg_wb),
    .ex_mem    (ex_mem),
    .ex_ex     (ex_ex),
    .pending   (pending),
    .mul_busy  (mul_busy),
    .mem_busy  (mem_busy),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  bit          m_pend[32];
  int          m_mul;
  bit          m_mem;
  int          m_scnt;
  bit          m_exv;
  logic [14:0] m_rs;
  logic [1:0]  m_wb;
  logic [1:0]  m_mm;
  logic [3:0]  m_ex;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_stall();
    int  srcs[$];
    int  rd;
    bit  st;
    st   = 1'b0;
    rd   = int'(id_rs[4:0]);
    srcs = {int'(id_rs[9:5]), int'(id_rs[14:10])};
    if (id_mem[0] || (id_ex[3] && !id_reg_wb[1])) srcs.push_back(rd);
    foreach (srcs[i]) if (srcs[i] != 0 && m_pend[srcs[i]]) st = 1'b1;
    if (id_reg_wb[1] && rd != 0 && m_pend[rd]) st = 1'b1;
    if (id_ex[2] && m_mul > 0) st = 1'b1;
    if (id_mem != 2'b00 && m_mem) st = 1'b1;
    return st;
  endfunction

  function automatic bit m_issue();
    return id_valid && !flush && !m_stall();
  endfunction

  task automatic model_reset();
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_mul  = 0;
    m_mem  = 1'b0;
    m_scnt = 0;
    m_exv  = 1'b0;
    m_rs   = '0;
    m_wb   = '0;
    m_mm   = '0;
    m_ex   = '0;
  endtask

  // Advance the model by one rising edge using the inputs currently applied.
  task automatic model_edge();
    bit iss;
    iss = m_issue();
    if (iss && id_ex[2]) m_mul = MulLat;
    else if (m_mul > 0) m_mul--;
    if (iss && id_mem != 2'b00) m_mem = 1'b1;
    else if (mem_done) m_mem = 1'b0;
    if (wb_valid) m_pend[int'(wb_rd)] = 1'b0;
    if (iss && id_reg_wb[1]) m_pend[int'(id_rs[4:0])] = 1'b1;
    m_pend[0] = 1'b0;
    if (id_valid && !flush && !iss && m_scnt < 65535) m_scnt++;
    m_exv = iss;
    if (iss) begin
      m_rs = id_rs;
      m_wb = id_reg_wb;
      m_mm = id_mem;
      m_ex = id_ex;
    end
  endtask

  task automatic check_outputs();
    logic [31:0] p;
    for (int i = 0; i < 32; i++) p[i] = m_pend[i];
    check("ex_valid", ex_valid, m_exv);
    check("ex_rs", ex_rs, m_rs);
    check("ex_reg_wb", ex_reg_wb, m_wb);
    check("ex_mem", ex_mem, m_mm);
    check("ex_ex", ex_ex, m_ex);
    check("pending", pending, p);
    check("mul_busy", mul_busy, m_mul > 0);
    check("mem_busy", mem_busy, m_mem);
    check("stall_cnt", stall_cnt, m_scnt);
  endtask

  task automatic step();
    #1;
    check("id_ready", id_ready, m_issue() || (id_valid && flush));
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic drive(input logic v, input logic [14:0] rs, input logic [1:0] wb,
                       input logic [1:0] mm, input logic [3:0] ex);
    id_valid  = v;
    id_rs     = rs;
    id_reg_wb = wb;
    id_mem    = mm;
    id_ex     = ex;
  endtask

  // Retire everything in flight so the next scenario starts hazard-free.
  task automatic drain();
    id_valid = 1'b0;
    flush    = 1'b0;
    for (int r = 1; r < 32; r++) begin
      if (m_pend[r]) begin
        wb_valid = 1'b1;
        wb_rd    = 5'(r);
        step();
      end
    end
    wb_valid = 1'b0;
    mem_done = 1'b1;
    step();
    mem_done = 1'b0;
    repeat (MulLat + 1) step();
  endtask

  initial begin
    bit took;
    rstn = 1'b1;
    drive(1'b0, '0, '0, '0, '0);
    flush    = 1'b0;
    wb_valid = 1'b0;
    wb_rd    = '0;
    mem_done = 1'b0;
    model_reset();
    #1 rstn = 1'b0;
    #2;
    check_outputs();
    @(posedge clk);
    #1 rstn = 1'b1;

    // RAW on r3, released one cycle after its writeback
    drive(1'b1, 15'h0C43, 2'b10, 2'b00, 4'b0000);
    step();
    check("A first issue", ex_valid, 1);
    check("A pend r3", pending[3], 1);
    drive(1'b1, {5'd1, 5'd3, 5'd4}, 2'b10, 2'b00, 4'b0000);
    repeat (3) step();
    check("A stall_cnt", stall_cnt, 3);
    wb_valid = 1'b1;
    wb_rd    = 5'd3;
    step();
    check("A wb not bypassed", ex_valid, 0);
    wb_valid = 1'b0;
    step();
    check("A issued", ex_valid, 1);
    check("A stall_cnt final", stall_cnt, 4);
    drain();

    // Back-to-back multiplies
    drive(1'b1, {5'd1, 5'd2, 5'd5}, 2'b10, 2'b00, 4'b0100);
    step();
    check("B mul_busy", mul_busy, 1);
    drive(1'b1, {5'd1, 5'd2, 5'd6}, 2'b10, 2'b00, 4'b0100);
    for (int c = 0; c < 3; c++) begin
      step();
      check("B mul stalled", ex_valid, 0);
    end
    step();
    check("B second mul", ex_valid, 1);
    check("B ex_ex mul", ex_ex[2], 1);
    drain();

    // Load then store, then issue coincident with mem_done
    drive(1'b1, {5'd1, 5'd2, 5'd7}, 2'b11, 2'b10, 4'b0000);
    step();
    check("C mem_busy", mem_busy, 1);
    drive(1'b1, {5'd1, 5'd2, 5'd8}, 2'b00, 2'b01, 4'b0000);
    repeat (2) step();
    mem_done = 1'b1;
    step();
    check("C done not bypassed", ex_valid, 0);
    check("C mem cleared", mem_busy, 0);
    mem_done = 1'b0;
    step();
    check("C store issued", ex_valid, 1);
    check("C store ex_mem", ex_mem, 2'b01);
    drive(1'b1, {5'd1, 5'd2, 5'd9}, 2'b10, 2'b10, 4'b0000);
    mem_done = 1'b1;
    step();
    step();
    check("C issue+done issued", ex_valid, 1);
    check("C issue+done busy", mem_busy, 1);
    mem_done = 1'b0;

    // Flush a stalled instruction
    drive(1'b1, {5'd1, 5'd2, 5'd10}, 2'b10, 2'b10, 4'b0000);
    step();
    flush = 1'b1;
    #1;
    check("D flush id_ready", id_ready, 1);
    step();
    check("D flush ex_valid", ex_valid, 0);
    flush = 1'b0;
    drain();

    // Same-cycle writeback and set of r5; rd=0 never pending
    drive(1'b1, {5'd1, 5'd2, 5'd5}, 2'b10, 2'b00, 4'b0000);
    wb_valid = 1'b1;
    wb_rd    = 5'd5;
    step();
    check("E pend r5", pending[5], 1);
    wb_valid = 1'b0;
    drive(1'b1, {5'd1, 5'd2, 5'd0}, 2'b10, 2'b00, 4'b0000);
    step();
    check("E rd0 issued", ex_valid, 1);
    check("E pend r0", pending[0], 0);

    // Long stall on r5 saturates the counter, then async reset mid-stall
    drive(1'b1, {5'd5, 5'd1, 5'd11}, 2'b10, 2'b00, 4'b0000);
    for (int c = 0; c < 70000; c++) begin
      @(posedge clk);
      model_edge();
    end
    #1;
    check("F stall_cnt sat", stall_cnt, 16'hFFFF);
    check_outputs();
    #2 rstn = 1'b0;
    #1;
    check("R ex_valid", ex_valid, 0);
    check("R ex_rs", ex_rs, 0);
    check("R ex_reg_wb", ex_reg_wb, 0);
    check("R ex_mem", ex_mem, 0);
    check("R ex_ex", ex_ex, 0);
    check("R pending", pending, 0);
    check("R mul_busy", mul_busy, 0);
    check("R mem_busy", mem_busy, 0);
    check("R stall_cnt", stall_cnt, 0);
    model_reset();
    @(posedge clk);
    #1 rstn = 1'b1;
    step();
    check("R first issue", ex_valid, 1);
    drain();

    // Randomized traffic; an instruction is held in ID until consumed
    took = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if (took || !id_valid) begin
        drive(1'($urandom_range(0, 9) < 8),
              {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))},
              2'($urandom),
              ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 2)) : 2'b00,
              {1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 3) == 0), 2'($urandom)});
      end
      flush    = ($urandom_range(0, 9) == 0);
      mem_done = ($urandom_range(0, 3) == 0);
      wb_valid = ($urandom_range(0, 2) == 0);
      wb_rd    = 5'($urandom_range(0, 7));
      took     = m_issue() || (id_valid && flush);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/issue_ctrl.md
ISSUE_CTRL -- requirements
Module: issue_ctrl

Interface
REQ-001 Parameter MUL_LAT, default 3, SHALL set the non-pipelined multiplier occupancy in cycles (legal range 1..15).
REQ-002 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-003 rstn  in  1  reset, asynchronous, active-low.
REQ-004 id_valid  in  1  decoded instruction present in ID.
REQ-005 id_rs  in  15  {rs2,rs1,rs0} from decoder; rs0 is the destination or the third source.
REQ-006 id_reg_wb  in  2  {REG_write, RES_MUX}; id_mem  in  2  {MEM_read, MEM_write}; id_ex  in  4  {is_branch, is_MUL, ALU_in0_MUX, ALU_in1_MUX}.
REQ-007 flush  in  1  taken branch; ID instruction is wrong-path.
REQ-008 wb_valid  in  1, wb_rd  in  5  register writeback completed.
REQ-009 mem_done  in  1  outstanding memory access completed.
REQ-010 id_ready  out  1  ID instruction consumed this cycle (issued or dropped).
REQ-011 ex_valid  out  1, ex_rs  out  15, ex_reg_wb  out  2, ex_mem  out  2, ex_ex  out  4  registered issue to EX.
REQ-012 pending  out  32  scoreboard, bit n set means rn has an in-flight writer.
REQ-013 mul_busy  out  1, mem_busy  out  1, stall_cnt  out  16  status and performance counter.

Function
REQ-014 Sources SHALL be rs1 and rs2 always, plus rs0 when id_mem[0]=1 or (id_ex[3]=1 and id_reg_wb[1]=0).
REQ-015 Destination SHALL be rs0 when id_reg_wb[1]=1; register 0 SHALL never be pending, checked or set.
REQ-016 RAW stall SHALL be asserted when any source has its pending bit set; WAW stall SHALL be asserted when the destination is pending.
REQ-017 Structural stall SHALL be asserted when id_ex[2]=1 and mul_busy=1, or when (id_mem!=0) and mem_busy=1.
REQ-018 Hazard checks SHALL use registered state only; a same-cycle wb_valid or mem_done SHALL NOT be bypassed, giving a minimum one-cycle stall after completion.
REQ-019 issue = id_valid & ~flush & ~stall; id_ready = issue | (id_valid & flush).
REQ-020 On flush, the ID instruction SHALL be dropped: no scoreboard, counter or ex_* update other than ex_valid<=0.
REQ-021 On issue, ex_* SHALL load id_* next edge with ex_valid<=1; otherwise ex_valid<=0 and other ex_* hold.
REQ-022 On issue with a destination, pending[rs0] SHALL set; wb_valid SHALL clear pending[wb_rd]; same-register set and clear in one cycle SHALL leave the bit set.
REQ-023 A MUL issue SHALL load the 4-bit mul counter with MUL_LAT; the counter SHALL otherwise decrement to 0 and hold; mul_busy = (counter!=0).
REQ-024 A memory issue SHALL set mem_busy; mem_done SHALL clear it; simultaneous issue and mem_done SHALL leave it set; mem_done while idle SHALL be ignored.
REQ-025 stall_cnt SHALL increment each cycle with id_valid=1, flush=0, issue=0, saturating at 16'hFFFF.
REQ-026 wb_valid with wb_rd not pending, or wb_rd=0, SHALL have no effect.

Reset
REQ-027 rstn=0 SHALL immediately clear pending, mul counter, mem_busy, stall_cnt, ex_valid and all ex_* fields to 0, regardless of clk.
REQ-028 Reset mid-operation SHALL discard all in-flight tracking; the first cycle after deassertion SHALL issue any valid instruction with no hazard.

Verification
REQ-029 ADD r3 (rs=15'h0C43 form, wb=10) issued, next ADD reading r3 -> stalls, stall_cnt increments each cycle until wb_valid,wb_rd=3 plus one cycle, then issues.
REQ-030 MUL issued with MUL_LAT=3, second MUL next cycle -> mul_busy=1 for 3 cycles, second MUL issues on cycle 4, ex_ex[2]=1.
REQ-031 LD issued, ST following -> stall until mem_done, issue the cycle after; issue and mem_done together -> mem_busy stays 1.
REQ-032 Stalled instruction with flush=1 -> id_ready=1, ex_valid=0, pending unchanged, stall_cnt unchanged.
REQ-033 wb_valid,wb_rd=5 in same cycle as issue writing r5 -> pending[5]=1 afterwards; instruction with rd=0 -> pending stays 0.
REQ-034 Force stall 70000 cycles -> stall_cnt=16'hFFFF, no wrap; rstn pulse mid-stall -> all outputs 0 asynchronously.
